// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer_pkg
//  Purpose  : Shared constants for the countdown timer: state encoding and
//             the default counter width.
//  Revision : 1.0  initial release
// ============================================================================
package countdown_timer_pkg;

   // Default counter / load-value width
   localparam int N_DEFAULT = 8;

   // Controller state encoding
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_PAUSED = 2'd2;

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Loadable down-counter with one-shot and periodic modes. Counts
//             down on qualified ticks and emits a one-cycle done strobe at
//             expiry, then reloads (periodic) or returns to idle (one-shot).
//  Revision : 1.0  initial release
// ============================================================================
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         tick_en_i,
   input  logic         start_i,
   input  logic [N-1:0] load_value_i,
   input  logic         periodic_i,
   input  logic         pause_i,
   input  logic         resume_i,
   input  logic         abort_i,
   output logic [N-1:0] count_o,
   output logic         busy_o,
   output logic         paused_o,
   output logic         done_o
);

   state_t         state_q,  state_d;
   logic [N-1:0]   count_q,  count_d;
   logic [N-1:0]   reload_q, reload_d;
   logic           mode_q,   mode_d;
   logic           done_q,   done_d;

   // State, count, reload/mode latches and the done strobe register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
      end
   end

   // Next state / next count, resolving controls as abort > start > pause > resume
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      done_d   = 1'b0;

      if (abort_i) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (start_i) begin
         // A concurrent tick is dropped: the loaded value is the first count
         reload_d = load_value_i;
         mode_d   = periodic_i;
         count_d  = load_value_i;
         state_d  = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pause_i) begin
                  state_d = ST_PAUSED;
               end else if (tick_en_i) begin
                  if (count_q != '0) begin
                     count_d = count_q - N'(1);
                  end else begin
                     // Zero is handled here so the decrement never wraps
                     done_d = 1'b1;
                     if (mode_q) begin
                        count_d = reload_q;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end
            ST_PAUSED: begin
               // Pause outranks resume, so both high keeps us frozen
               if (!pause_i && resume_i) begin
                  state_d = ST_RUN;
               end
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // Outputs decode straight from registers only
   always_comb begin
      count_o  = count_q;
      busy_o   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
      paused_o = (state_q == ST_PAUSED);
      done_o   = done_q;
   end

endmodule : countdown_timer
`default_nettype wire
